// File: rtl/ram_arbiter_if.sv
// Master-side request/grant signals and RAM control strobes of ram_arbiter.
interface ram_arbiter_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          m0_req;
  logic          m1_req;
  logic          m0_we;
  logic          m1_we;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt;
  logic          m1_gnt;
  logic          m0_ack;
  logic          m1_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_oa;
  logic          ram_wa;

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_ack, m1_ack, rdata, ram_addr, ram_cs, ram_oa, ram_wa
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_gnt, m1_gnt, m0_ack, m1_ack, rdata, ram_addr, ram_cs, ram_oa, ram_wa
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port async RAM: SETUP/ACCESS/DONE cycle per grant.
// Define RAM_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module ram_arbiter (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave mif,
  inout  wire  [7:0]   bus
);
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic          cs_q, cs_d;
  logic          oa_q, oa_d;
  logic          wa_q, wa_d;
  logic          win_c;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic          last_q, last_d;
`endif

  // Winner select: 0 = master 0, 1 = master 1
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    win_c = ~mif.m0_req;
`else
    if (mif.m0_req && mif.m1_req) begin
      win_c = ~last_q;
    end else begin
      win_c = ~mif.m0_req;
    end
`endif
  end

  // Next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    gnt_d      = gnt_q;
    ack_d      = 2'b00;
    cs_d       = 1'b0;
    oa_d       = 1'b0;
    wa_d       = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (mif.m0_req || mif.m1_req) begin
          sel_d      = win_c;
          we_d       = win_c ? mif.m1_we    : mif.m0_we;
          addr_d     = win_c ? mif.m1_addr  : mif.m0_addr;
          wdata_d    = win_c ? mif.m1_wdata : mif.m0_wdata;
          ram_addr_d = win_c ? mif.m1_addr  : mif.m0_addr;
          gnt_d      = win_c ? 2'b10 : 2'b01;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d     = win_c;
`endif
          state_d    = SETUP;
        end
      end
      SETUP: begin
        cs_d    = 1'b1;
        wa_d    = we_q;
        oa_d    = ~we_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = bus;
        end
        ack_d   = sel_q ? 2'b10 : 2'b01;
        state_d = DONE;
      end
      DONE: begin
        gnt_d      = 2'b00;
        ram_addr_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      cs_q       <= 1'b0;
      oa_q       <= 1'b0;
      wa_q       <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      cs_q       <= cs_d;
      oa_q       <= oa_d;
      wa_q       <= wa_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  // Write data only while the RAM is strobed for a write
  assign bus = (cs_q && wa_q) ? wdata_q : 'z;

  assign mif.m0_gnt   = gnt_q[0];
  assign mif.m1_gnt   = gnt_q[1];
  assign mif.m0_ack   = ack_q[0];
  assign mif.m1_ack   = ack_q[1];
  assign mif.rdata    = rdata_q;
  assign mif.ram_addr = ram_addr_q;
  assign mif.ram_cs   = cs_q;
  assign mif.ram_oa   = oa_q;
  assign mif.ram_wa   = wa_q;
endmodule
